// File: rtl/add_seq_ctrl_if.sv
// Request/result bundle for the sliced adder sequencer; master issues operands, slave computes.
interface add_seq_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/add_seq_ctrl.sv
// WIDTH-bit add/sub through one CHUNK-bit slice, LSB first; result valid NCHUNK cycles after accept.
// One op in flight: in_ready only in IDLE, result held in DONE until out_ready.
module add_seq_ctrl #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic          clk,
    input  logic          rst,
    add_seq_ctrl_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic             in_rdy;
    logic             out_vld;
    logic             accept;
    logic             last_slice;
    logic [CHUNK-1:0] a_s;
    logic [CHUNK-1:0] b_s;
    logic [CHUNK:0]   slice;
    logic             msb_cin;

    assign a_s        = a_r[idx*CHUNK +: CHUNK];
    assign b_s        = b_r[idx*CHUNK +: CHUNK];
    assign slice      = {1'b0, a_s} + {1'b0, b_s} + {{CHUNK{1'b0}}, carry_r};
    // Carry into the top bit recovered from its sum bit: s = a ^ b ^ c
    assign msb_cin    = slice[CHUNK-1] ^ a_s[CHUNK-1] ^ b_s[CHUNK-1];
    assign last_slice = (idx == IDXW'(NCHUNK - 1));
    assign accept     = bus.in_valid && in_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        out_vld   = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = !rst;
                if (bus.in_valid && !rst) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_vld = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept) begin
            // Subtract folds into add: a + ~b + 1
            a_r     <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.sub ? 1'b1 : bus.cin;
            idx     <= '0;
            sum_r   <= '0;
        end else if (state == RUN) begin
            sum_r[idx*CHUNK +: CHUNK] <= slice[CHUNK-1:0];
            carry_r                   <= slice[CHUNK];
            idx                       <= idx + 1'b1;
            if (last_slice) begin
                cout_r <= slice[CHUNK];
                ovf_r  <= msb_cin ^ slice[CHUNK];
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl at default WIDTH=64, CHUNK=16.
module tb_add_seq_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    add_seq_ctrl_if #(.WIDTH(64)) ifc ();

    add_seq_ctrl #(
        .WIDTH(64),
        .CHUNK(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a request from #1 after an edge; returns #1 after the accept edge.
    task automatic start_op(input logic [63:0] ta, input logic [63:0] tb_v,
                            input logic tcin, input logic tsub, output int waited);
        ifc.a        = ta;
        ifc.b        = tb_v;
        ifc.cin      = tcin;
        ifc.sub      = tsub;
        ifc.in_valid = 1'b1;
        waited       = 0;
        while (ifc.in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (ifc.out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic pop();
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (ifc.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", ifc.in_ready); end
        n_cmp++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", ifc.out_valid); end
        n_cmp++; if (ifc.sum !== 64'h0) begin n_err++; $display("FAIL reset_sum: got %h expected 0", ifc.sum); end
        n_cmp++; if ({ifc.cout, ifc.ovf} !== 2'b00) begin n_err++; $display("FAIL reset_cout_ovf: got %b expected 00", {ifc.cout, ifc.ovf}); end
        @(posedge clk); #1;
    endtask

    task automatic test_add_basic();
        int w, cyc;
        start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, w);
        n_cmp++; if (ifc.in_ready !== 1'b0) begin n_err++; $display("FAIL basic_busy_in_ready: got %b expected 0", ifc.in_ready); end
        wait_out(cyc);
        n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL basic_latency: got %0d cycles expected 4", cyc); end
        n_cmp++; if (ifc.sum !== 64'h0000_0000_0001_0000) begin n_err++; $display("FAIL basic_sum: got %h expected 0000000000010000", ifc.sum); end
        n_cmp++; if ({ifc.cout, ifc.ovf} !== 2'b00) begin n_err++; $display("FAIL basic_cout_ovf: got %b expected 00", {ifc.cout, ifc.ovf}); end
        pop();
        n_cmp++; if ({ifc.out_valid, ifc.in_ready} !== 2'b01) begin n_err++; $display("FAIL basic_after_pop: got vld/rdy %b expected 01", {ifc.out_valid, ifc.in_ready}); end
        n_cmp++; if (ifc.sum !== 64'h0000_0000_0001_0000) begin n_err++; $display("FAIL basic_sum_held_idle: got %h expected 0000000000010000", ifc.sum); end
    endtask

    task automatic test_ripple();
        int w, cyc;
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, w);
        wait_out(cyc);
        n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL ripple_latency: got %0d expected 4", cyc); end
        n_cmp++; if (ifc.sum !== 64'h0) begin n_err++; $display("FAIL ripple_sum: got %h expected 0", ifc.sum); end
        n_cmp++; if ({ifc.cout, ifc.ovf} !== 2'b10) begin n_err++; $display("FAIL ripple_cout_ovf: got %b expected 10", {ifc.cout, ifc.ovf}); end
        pop();
    endtask

    task automatic test_ovf();
        int w, cyc;
        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, w);
        wait_out(cyc);
        n_cmp++; if (ifc.sum !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL ovf_sum: got %h expected 8000000000000000", ifc.sum); end
        n_cmp++; if ({ifc.cout, ifc.ovf} !== 2'b01) begin n_err++; $display("FAIL ovf_cout_ovf: got %b expected 01", {ifc.cout, ifc.ovf}); end
        pop();
    endtask

    task automatic test_sub();
        int w, cyc;
        start_op(64'h5, 64'h7, 1'b1, 1'b1, w);
        // Operands scrambled mid-run must not leak into the result
        ifc.a   = 64'hDEAD_BEEF_0000_1111;
        ifc.b   = 64'h1234_5678_9ABC_DEF0;
        ifc.sub = 1'b0;
        ifc.cin = 1'b1;
        wait_out(cyc);
        n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL sub_latency: got %0d expected 4", cyc); end
        n_cmp++; if (ifc.sum !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL sub_neg_sum: got %h expected fffffffffffffffe", ifc.sum); end
        n_cmp++; if ({ifc.cout, ifc.ovf} !== 2'b00) begin n_err++; $display("FAIL sub_neg_cout_ovf: got %b expected 00", {ifc.cout, ifc.ovf}); end
        pop();
        start_op(64'h7, 64'h5, 1'b0, 1'b1, w);
        wait_out(cyc);
        n_cmp++; if (ifc.sum !== 64'h2) begin n_err++; $display("FAIL sub_pos_sum: got %h expected 2", ifc.sum); end
        n_cmp++; if ({ifc.cout, ifc.ovf} !== 2'b10) begin n_err++; $display("FAIL sub_pos_cout_ovf: got %b expected 10", {ifc.cout, ifc.ovf}); end
        pop();
    endtask

    task automatic test_backpressure();
        int w, cyc;
        logic ok;
        start_op(64'h1234, 64'h1111, 1'b0, 1'b0, w);
        wait_out(cyc);
        n_cmp++; if (ifc.sum !== 64'h2345) begin n_err++; $display("FAIL bp_sum: got %h expected 2345", ifc.sum); end
        ifc.a        = 64'd10;
        ifc.b        = 64'd20;
        ifc.cin      = 1'b0;
        ifc.sub      = 1'b0;
        ifc.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            ok = (ifc.sum === 64'h2345) && (ifc.cout === 1'b0) && (ifc.ovf === 1'b0) &&
                 (ifc.in_ready === 1'b0) && (ifc.out_valid === 1'b1);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL bp_hold_cycle%0d: got sum=%h cout=%b ovf=%b rdy=%b vld=%b expected sum=2345 cout=0 ovf=0 rdy=0 vld=1",
                         i, ifc.sum, ifc.cout, ifc.ovf, ifc.in_ready, ifc.out_valid);
            end
        end
        pop();
        n_cmp++; if ({ifc.out_valid, ifc.in_ready} !== 2'b01) begin n_err++; $display("FAIL bp_release_idle: got vld/rdy %b expected 01", {ifc.out_valid, ifc.in_ready}); end
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        n_cmp++; if (ifc.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_new_accept: got in_ready %b expected 0", ifc.in_ready); end
        wait_out(cyc);
        n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL bp_new_latency: got %0d expected 4", cyc); end
        n_cmp++; if (ifc.sum !== 64'd30) begin n_err++; $display("FAIL bp_new_sum: got %h expected 1e", ifc.sum); end
        pop();
    endtask

    task automatic test_reset_abort();
        int w, cyc;
        logic seen;
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, w);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL abort_out_valid: got %b expected 0", ifc.out_valid); end
        n_cmp++; if (ifc.sum !== 64'h0) begin n_err++; $display("FAIL abort_sum: got %h expected 0", ifc.sum); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++; if ({ifc.out_valid, ifc.in_ready} !== 2'b01) begin n_err++; $display("FAIL abort_release: got vld/rdy %b expected 01", {ifc.out_valid, ifc.in_ready}); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ifc.out_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_stale_valid: got %b expected 0", seen); end
        start_op(64'd3, 64'd4, 1'b0, 1'b0, w);
        wait_out(cyc);
        n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL abort_next_latency: got %0d expected 4", cyc); end
        n_cmp++; if (ifc.sum !== 64'd7) begin n_err++; $display("FAIL abort_next_sum: got %h expected 7", ifc.sum); end
        n_cmp++; if ({ifc.cout, ifc.ovf} !== 2'b00) begin n_err++; $display("FAIL abort_next_cout_ovf: got %b expected 00", {ifc.cout, ifc.ovf}); end
        pop();
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.a         = '0;
        ifc.b         = '0;
        ifc.cin       = 1'b0;
        ifc.sub       = 1'b0;
        ifc.out_ready = 1'b0;
        test_reset();
        test_add_basic();
        test_ripple();
        test_ovf();
        test_sub();
        test_backpressure();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
